// File: rtl/router_fifo_if.sv
// Router FIFO bus: core write side, destination read side, soft reset and status.
// Ports (slave view): write_enb, lfd_state, data_in, read_enb, soft_reset in;
//                     data_out, full, empty out.
interface router_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  soft_reset;
    logic                  write_enb;
    logic                  lfd_state;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  read_enb;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;

    modport master (
        output soft_reset, write_enb, lfd_state, data_in, read_enb,
        input  data_out, full, empty
    );

    modport slave (
        input  soft_reset, write_enb, lfd_state, data_in, read_enb,
        output data_out, full, empty
    );
endinterface

// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router.
// Stores bytes with a header marker bit, tracks remaining bytes of the packet
// being read, and idles data_out at zero once a packet has been fully read.
// Ports: clock, reset (async, active-high), bus (router_fifo_if.slave):
//   write_enb/lfd_state/data_in write side, read_enb/data_out read side,
//   soft_reset synchronous clear, full/empty status (combinational).
// The header length field lives in bits [7:2], so DATA_WIDTH must be >= 8.
module router_fifo #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic           clock,
    input  logic           reset,
    router_fifo_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned WW = DATA_WIDTH + 1;

    logic [WW-1:0]         mem [DEPTH];
    logic [PW-1:0]         wp;
    logic [PW-1:0]         rp;
    logic [5:0]            pcnt;
    logic [DATA_WIDTH-1:0] data_q;
    logic [WW-1:0]         rd_word;
    logic                  full_c;
    logic                  empty_c;
    logic                  wr_ok;
    logic                  rd_ok;

    // Status from pre-edge pointers; MSB is the wrap bit.
    assign empty_c = (wp == rp);
    assign full_c  = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
    assign wr_ok   = bus.write_enb & ~full_c;
    assign rd_ok   = bus.read_enb & ~empty_c;
    assign rd_word = mem[rp[AW-1:0]];

    assign bus.full     = full_c;
    assign bus.empty    = empty_c;
    assign bus.data_out = data_q;

    // Storage array; contents are not cleared by either reset.
    always_ff @(posedge clock) begin
        if (wr_ok && !bus.soft_reset) begin
            mem[wp[AW-1:0]] <= {bus.lfd_state, bus.data_in};
        end
    end

    // Pointers, packet counter and registered read data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp     <= '0;
            rp     <= '0;
            pcnt   <= '0;
            data_q <= '0;
        end else if (bus.soft_reset) begin
            wp     <= '0;
            rp     <= '0;
            pcnt   <= '0;
            data_q <= '0;
        end else begin
            if (wr_ok) begin
                wp <= wp + PW'(1);
            end
            if (rd_ok) begin
                rp     <= rp + PW'(1);
                data_q <= rd_word[DATA_WIDTH-1:0];
                // Header: payload length plus the trailing parity byte.
                if (rd_word[DATA_WIDTH]) begin
                    pcnt <= rd_word[7:2] + 6'd1;
                end else if (pcnt != 6'd0) begin
                    pcnt <= pcnt - 6'd1;
                end
            end else if (pcnt == 6'd0) begin
                // Bus idles at zero once the last byte of a packet is consumed.
                data_q <= '0;
            end
        end
    end
endmodule

// File: doc/router_fifo.md
# router_fifo

Per-destination output buffer of the 1x3 router, between the router core (writes header, payload and parity bytes of the packet it is routing) and the destination interface (reads through `read_enb`/`data_out`). Stores bytes plus a header marker bit, tracks remaining bytes of the packet being read out, and supports a synchronous soft reset issued by the core on destination timeout. The router instantiates three, one per destination.

## Interface
- `DEPTH`, 16: entries; power of two, 4..64.
- `DATA_WIDTH`, 8: payload byte width; stored word is `DATA_WIDTH+1` (bit `DATA_WIDTH` = header marker).
- `clock` input 1: single clock, all state on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `soft_reset` input 1: synchronous clear, same effect as `reset` at next edge.
- `write_enb` input 1: write request for `data_in`.
- `lfd_state` input 1: qualifies current write as packet header byte (marker = 1).
- `data_in` input `DATA_WIDTH`: byte to store.
- `read_enb` input 1: read request from destination.
- `data_out` output `DATA_WIDTH`: registered read data.
- `full` output 1: `DEPTH` entries occupied.
- `empty` output 1: zero entries occupied.

## Operation
- Storage: `DEPTH` x (`DATA_WIDTH`+1) array; write pointer `wp`, read pointer `rp`, each `log2(DEPTH)+1` bits; low bits index, MSB is wrap bit.
- `empty` = (`wp` == `rp`); `full` = index bits equal and wrap bits differ. Both combinational from pointers.
- Write accepted iff `write_enb` & ~`full`: store {`lfd_state`, `data_in`} at `wp`, `wp` += 1 (modulo 2*DEPTH). Write while full: dropped, no state change.
- Read accepted iff `read_enb` & ~`empty`: `data_out` <= stored byte at `rp`, `rp` += 1. Read while empty: dropped, `data_out` holds.
- Full/empty evaluated on pre-edge pointers: simultaneous read+write when full -> read accepted, write dropped; when empty -> write accepted, read dropped; otherwise both accepted, occupancy unchanged.
- Packet counter `pcnt` (6 bits): on accepted read of an entry with marker=1, `pcnt` <= `data[7:2]` (payload length) + 1 (parity byte). On accepted read with marker=0 and `pcnt` != 0, `pcnt` -= 1. Never underflows.
- When `pcnt` is 0 and no read is accepted, `data_out` <= 0 next edge (bus idles at 0 after last parity byte is consumed). When `pcnt` != 0 and no read, `data_out` holds.
- `reset` (async) or `soft_reset` (sync, priority over simultaneous read/write): `wp`=`rp`=0, `pcnt`=0, `data_out`=0, array contents need not clear; writes/reads in the same cycle as `soft_reset` are discarded.

## Timing
- Reset values: `data_out`=0, `empty`=1, `full`=0.
- Write-to-`empty` deassert: 1 edge (visible after the accepting edge).
- Read latency: `data_out` valid the cycle after the edge that accepts `read_enb`.
- Fall-through not supported; minimum write-to-read-data latency 2 cycles.
- Wrap-around: pointer index rolls from `DEPTH-1` to 0, wrap bit toggles; full/empty remain correct across any number of wraps.
- Reset asserted mid-packet: everything cleared immediately; next header written restarts normally.
- Sustained throughput: one write and one read per cycle.

## Test plan
- Reset then idle: `reset`=1 for 2 cycles, release -> `empty`=1, `full`=0, `data_out`=0, unchanged after 10 idle cycles.
- Single packet: write header 0x0D (lfd_state=1, length 3), payload 0x11,0x22,0x33, parity 0x2F; read 5 continuous -> `data_out` 0x0D,0x11,0x22,0x33,0x2F one cycle after each read, then 0x00 the cycle after the last read with `read_enb` low.
- Fill/overflow: 17 writes 0x00..0x10 with no reads -> `full`=1 after 16th, 17th dropped; 16 reads return 0x00..0x0F, then `empty`=1.
- Simultaneous access: when full, `write_enb`=`read_enb`=1 -> read returns oldest, write dropped, `full` drops; when empty, both high -> `empty`=0, `data_out` unchanged.
- Wrap: 40 write/read pairs at one-entry occupancy -> data order preserved, `full` never asserts.
- Soft reset mid-packet: 3 of 5 packet bytes read, pulse `soft_reset` -> next cycle `empty`=1, `data_out`=0; subsequent new packet reads correctly.
